// File: rtl/mux16_pkg.sv
// rtl/mux16_pkg.sv - shared constants and state type for the 16-channel TDM mux/demux pair
package mux16_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/demux16_tdm_collector_if.sv
// rtl/demux16_tdm_collector_if.sv - serial beat input and parallel frame output bundle
interface demux16_tdm_collector_if;
    import mux16_pkg::*;

    logic             in;
    logic             in_valid;
    logic             frame_start;
    logic [N_CH-1:0]  out;
    logic             out_valid;
    logic [SEL_W-1:0] slot;
    logic             locked;
    logic             sync_err;

    modport master (
        output in, in_valid, frame_start,
        input  out, out_valid, slot, locked, sync_err
    );

    modport slave (
        input  in, in_valid, frame_start,
        output out, out_valid, slot, locked, sync_err
    );

endinterface

// File: rtl/dec4to16.sv
// rtl/dec4to16.sv - gated 4-to-16 one-hot decoder, inverse of the 16:1 select mux
module dec4to16
    import mux16_pkg::*;
(
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [N_CH-1:0]  onehot_o
);

    assign onehot_o = en_i ? (N_CH'(1) << sel_i) : '0;

endmodule

// File: rtl/demux16_tdm_collector.sv
// rtl/demux16_tdm_collector.sv - slot-counting serial demux assembling 16-channel frames
module demux16_tdm_collector
    import mux16_pkg::*;
#(
    parameter bit SYNC_EVERY_FRAME = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    demux16_tdm_collector_if.slave    bus
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic [SEL_W-1:0] wr_slot;
    logic             wr_en;
    logic [N_CH-1:0]  wr_onehot;
    logic [N_CH-2:0]  shadow_q, shadow_d;
    logic [N_CH-1:0]  out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q, sync_err_d;

    dec4to16 u_dec (
        .sel_i    (wr_slot),
        .en_i     (wr_en),
        .onehot_o (wr_onehot)
    );

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wr_slot    = slot_q;
        wr_en      = 1'b0;
        sync_err_d = 1'b0;
        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.frame_start) begin
                        wr_slot = '0;
                        wr_en   = 1'b1;
                        slot_d  = SEL_W'(1);
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.frame_start && slot_q != '0) begin
                        // Truncated frame: restart assembly with this beat as slot 0.
                        sync_err_d = 1'b1;
                        wr_slot    = '0;
                        wr_en      = 1'b1;
                        slot_d     = SEL_W'(1);
                    end else if (!bus.frame_start && slot_q == '0 && SYNC_EVERY_FRAME) begin
                        sync_err_d = 1'b1;
                        slot_d     = '0;
                        state_d    = HUNT;
                    end else begin
                        wr_en  = 1'b1;
                        slot_d = slot_q + SEL_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // The slot-15 enable has no shadow bit; it commits the whole frame instead.
    always_comb begin
        shadow_d    = shadow_q;
        for (int i = 0; i < N_CH - 1; i++) begin
            if (wr_onehot[i]) begin
                shadow_d[i] = bus.in;
            end
        end
        out_valid_d = wr_onehot[N_CH-1];
        out_d       = wr_onehot[N_CH-1] ? {bus.in, shadow_q} : out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot      = slot_q;
    assign bus.locked    = (state_q == COLLECT);
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_demux16_tdm_collector.sv
// tb/tb_demux16_tdm_collector.sv - directed and random checks of both sync modes against a frame model
module tb_demux16_tdm_collector;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux16_tdm_collector_if bus1 ();
    demux16_tdm_collector_if bus0 ();

    demux16_tdm_collector #(.SYNC_EVERY_FRAME(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    demux16_tdm_collector #(.SYNC_EVERY_FRAME(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    int n_cmp = 0;
    int n_err = 0;

    // Index k: 1 = every frame needs frame_start, 0 = only the first one does.
    bit        m_lk  [2];
    int        m_sl  [2];
    bit [15:0] m_sh  [2];
    bit [15:0] m_out [2];
    bit        m_ov  [2];
    bit        m_se  [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lk[k] = 0; m_sl[k] = 0; m_sh[k] = '0; m_out[k] = '0; m_ov[k] = 0; m_se[k] = 0;
        end
    endfunction

    function automatic void model_beat(input bit b, input bit v, input bit fs);
        for (int k = 0; k < 2; k++) begin
            m_ov[k] = 0;
            m_se[k] = 0;
            if (!v) continue;
            if (!m_lk[k]) begin
                if (fs) begin
                    m_sh[k][0] = b; m_sl[k] = 1; m_lk[k] = 1;
                end
            end else if (fs && m_sl[k] != 0) begin
                m_se[k] = 1; m_sh[k][0] = b; m_sl[k] = 1;
            end else if (!fs && m_sl[k] == 0 && k == 1) begin
                m_se[k] = 1; m_lk[k] = 0;
            end else begin
                m_sh[k][m_sl[k]] = b;
                if (m_sl[k] == 15) begin
                    m_out[k] = m_sh[k]; m_ov[k] = 1; m_sl[k] = 0;
                end else begin
                    m_sl[k] = m_sl[k] + 1;
                end
            end
        end
    endfunction

    task automatic check_dut(input int k, input logic [15:0] o, input logic ov,
                             input logic [3:0] sl, input logic lk, input logic se);
        logic [3:0] esl;
        esl = 4'(m_sl[k]);
        n_cmp++;
        assert (o === m_out[k]) else begin n_err++; $error("FAIL out[%0d] got %h exp %h", k, o, m_out[k]); end
        n_cmp++;
        assert (ov === m_ov[k]) else begin n_err++; $error("FAIL out_valid[%0d] got %b exp %b", k, ov, m_ov[k]); end
        n_cmp++;
        assert (sl === esl) else begin n_err++; $error("FAIL slot[%0d] got %0d exp %0d", k, sl, esl); end
        n_cmp++;
        assert (lk === m_lk[k]) else begin n_err++; $error("FAIL locked[%0d] got %b exp %b", k, lk, m_lk[k]); end
        n_cmp++;
        assert (se === m_se[k]) else begin n_err++; $error("FAIL sync_err[%0d] got %b exp %b", k, se, m_se[k]); end
    endtask

    task automatic check_all();
        check_dut(1, bus1.out, bus1.out_valid, bus1.slot, bus1.locked, bus1.sync_err);
        check_dut(0, bus0.out, bus0.out_valid, bus0.slot, bus0.locked, bus0.sync_err);
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin n_err++; $error("FAIL %s got %h exp %h", tag, got, exp); end
    endtask

    task automatic drive(input bit b, input bit v, input bit fs);
        bus1.in = b; bus1.in_valid = v; bus1.frame_start = fs;
        bus0.in = b; bus0.in_valid = v; bus0.frame_start = fs;
    endtask

    task automatic beat(input bit b, input bit v, input bit fs);
        drive(b, v, fs);
        @(posedge clk);
        model_beat(b, v, fs);
        #1;
        check_all();
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic async_reset();
        drive(1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_out1", bus1.out, 16'h0000);
        chk("rst_out0", bus0.out, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [15:0] w, input bit fs_first, input int gap_after);
        for (int i = 0; i < 16; i++) begin
            beat(w[i], 1'b1, fs_first && i == 0);
            if (i == gap_after) begin
                for (int g = 0; g < 3; g++) begin
                    beat(1'b0, 1'b0, 1'b1);
                    chk("gap_slot", 16'(bus1.slot), 16'd8);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        chk("reset_out", bus1.out, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(16'hA5C3, 1'b1, -1);
        chk("a5c3_out", bus1.out, 16'hA5C3);
        chk("a5c3_ov", 16'(bus1.out_valid), 16'd1);
        chk("a5c3_lock", 16'(bus1.locked), 16'd1);

        send_frame(16'hA5C3, 1'b1, 7);
        chk("gap_out", bus0.out, 16'hA5C3);

        async_reset();
        for (int i = 0; i < 5; i++) beat(i[0], 1'b1, 1'b0);
        chk("hunt_lock1", 16'(bus1.locked), 16'd0);
        chk("hunt_lock0", 16'(bus0.locked), 16'd0);
        send_frame(16'h00FF, 1'b1, -1);
        chk("00ff_out", bus1.out, 16'h00FF);

        for (int i = 0; i < 9; i++) beat(1'b1, 1'b1, i == 0);
        send_frame(16'h1234, 1'b1, -1);
        chk("1234_out1", bus1.out, 16'h1234);
        chk("1234_out0", bus0.out, 16'h1234);

        send_frame(16'hBEEF, 1'b0, -1);
        chk("nofs_keep1", bus1.out, 16'h1234);
        chk("nofs_lock1", 16'(bus1.locked), 16'd0);
        chk("free_beef0", bus0.out, 16'hBEEF);

        for (int i = 0; i < 6; i++) beat(1'b1, 1'b1, i == 0);
        chk("pre_rst_slot", 16'(bus1.slot), 16'd6);
        async_reset();
        send_frame(16'h8001, 1'b1, -1);
        chk("8001_out1", bus1.out, 16'h8001);
        chk("8001_out0", bus0.out, 16'h8001);

        for (int n = 0; n < 800; n++) begin
            bit v, fs, b;
            v  = ($urandom % 4) != 0;
            b  = $urandom % 2;
            fs = v && ((m_sl[0] == 0) ? (($urandom % 10) != 0) : (($urandom % 25) == 0));
            beat(b, v, fs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
